// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and the lane-enable helper for the load/store bus master.
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    // Size code 3 is illegal; it yields no lanes (it is rejected as misaligned anyway).
    function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mips_cpu_bus_lane_steer.sv
// Combinational lane steering: byte enables, alignment check, store-data
// replication on the request side, and load-data extension on the return side.
module mips_cpu_bus_lane_steer
    import mips_cpu_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [1:0]  load_size,
    input  logic        load_signed,
    input  logic [31:0] load_data,
    output logic [3:0]  byteenable,
    output logic        misaligned,
    output logic [31:0] lane_data,
    output logic [31:0] ext_data
);

    assign byteenable = be_from_size(size, addr_lo);

    // Alignment check and store-data replication for the incoming request
    always_comb begin
        misaligned = 1'b0;
        lane_data  = store_data;
        case (size)
            SZ_BYTE: lane_data = {4{store_data[7:0]}};
            SZ_HALF: begin
                misaligned = addr_lo[0];
                lane_data  = {2{store_data[15:0]}};
            end
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Bus returns the selected lanes right-justified, so extension works from bit 0
    always_comb begin
        ext_data = load_data;
        case (load_size)
            SZ_BYTE: ext_data = {{24{load_signed & load_data[7]}}, load_data[7:0]};
            SZ_HALF: ext_data = {{16{load_signed & load_data[15]}}, load_data[15:0]};
            default: ext_data = load_data;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// Load/store bus master: one core request becomes one Avalon-style bus
// transaction, with waitrequest handling, optional timeout and load extension.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a request; misaligned requests go straight to RESP
// ST_ACCESS  | strobe and bus fields driven from registers until accepted
// ST_CAPTURE | bus read accepted last cycle; register extended readdata
// ST_RESP    | one-cycle resp_valid pulse
module mips_cpu_bus_lsu
    import mips_cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata
);

    // A zero TIMEOUT still needs a one-bit counter to keep the declaration legal.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       load_size;
    logic             load_signed;
    logic [3:0]       be_req;
    logic             misaligned;
    logic [31:0]      lane_data;
    logic [31:0]      ext_data;
    logic             timeout_hit;
    logic             unused_addr;

    assign req_ready   = (state == ST_IDLE);
    // Address bits above ADDR_W are intentionally dropped.
    assign unused_addr = ^req_addr;
    // Abort on the edge that closes the TIMEOUT-th consecutive stalled cycle.
    assign timeout_hit = (TIMEOUT != 0) && waitrequest &&
                         ((32'(wait_cnt) + 32'd1) >= TIMEOUT);

    mips_cpu_bus_lane_steer u_steer (
        .size        (req_size),
        .addr_lo     (req_addr[1:0]),
        .store_data  (req_wdata),
        .load_size   (load_size),
        .load_signed (load_signed),
        .load_data   (readdata),
        .byteenable  (be_req),
        .misaligned  (misaligned),
        .lane_data   (lane_data),
        .ext_data    (ext_data)
    );

    // Request sequencing with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            load_size   <= 2'd0;
            load_signed <= 1'b0;
            read        <= 1'b0;
            write       <= 1'b0;
            byteenable  <= 4'b0000;
            addr        <= '0;
            writedata   <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        load_size   <= req_size;
                        load_signed <= req_signed;
                        if (misaligned) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state      <= ST_ACCESS;
                            read       <= ~req_write;
                            write      <= req_write;
                            addr       <= req_addr[ADDR_W-1:0];
                            byteenable <= be_req;
                            writedata  <= lane_data;
                            wait_cnt   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (write) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end else if (timeout_hit) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ext_data;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// Scoreboard bench for mips_cpu_bus_lsu: directed requests push expected
// responses and bus transfers; negedge monitors pop and compare.
module tb_mips_cpu_bus_lsu;
    import mips_cpu_bus_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          stamp;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [23:0] addr;
        logic [31:0] wd;
    } bus_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;
    logic [23:0] addr;
    logic [31:0] writedata, readdata;

    logic        t_req_valid, t_req_ready, t_resp_valid, t_resp_err;
    logic [31:0] t_resp_rdata;
    logic        t_read, t_write;
    logic [3:0]  t_byteenable;
    logic [23:0] t_addr;
    logic [31:0] t_writedata;
    logic        t_waitrequest = 1'b1;
    logic [31:0] t_readdata = 32'h0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    resp_t resp_q[$];
    bus_t  bus_q[$];

    mips_cpu_bus_lsu #(.ADDR_W(24), .TIMEOUT(0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .read(read), .write(write),
        .byteenable(byteenable), .addr(addr), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    mips_cpu_bus_lsu #(.ADDR_W(24), .TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(1'b0),
        .req_size(2'd2), .req_signed(1'b0), .req_addr(32'h0000_0020),
        .req_wdata(32'h0), .resp_valid(t_resp_valid), .resp_err(t_resp_err),
        .resp_rdata(t_resp_rdata), .read(t_read), .write(t_write),
        .byteenable(t_byteenable), .addr(t_addr), .writedata(t_writedata),
        .waitrequest(t_waitrequest), .readdata(t_readdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-addressed memory with programmable wait states
    bit [7:0] mem [int];
    int wait_cfg = 0;
    int wait_seen;
    assign waitrequest = (read || write) && (wait_seen < wait_cfg);

    function automatic logic [31:0] bus_read(input logic [23:0] a, input logic [3:0] be);
        logic [31:0] d;
        int base;
        int j;
        d = 32'h0;
        j = 0;
        base = int'({a[23:2], 2'b00});
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                d[8*j +: 8] = mem.exists(base + i) ? mem[base + i] : 8'h00;
                j++;
            end
        end
        return d;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            wait_seen <= 0;
            readdata  <= 32'h0;
        end else if (read || write) begin
            if (waitrequest) begin
                wait_seen <= wait_seen + 1;
            end else begin
                wait_seen <= 0;
                if (write) begin
                    for (int i = 0; i < 4; i++)
                        if (byteenable[i]) mem[int'({addr[23:2], 2'b00}) + i] = writedata[8*i +: 8];
                end else begin
                    readdata <= bus_read(addr, byteenable);
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        resp_t r;
        if (!reset && resp_valid) begin
            if (resp_q.size() == 0) begin
                flag("resp_unexpected", "resp_valid with nothing outstanding");
            end else begin
                r = resp_q.pop_front();
                chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("resp_latency", cyc - r.stamp, r.lat);
            end
        end
    end

    // Bus monitor: fields must match the queued transfer for every strobe cycle
    always @(negedge clk) begin
        bus_t b;
        if (!reset && (read || write)) begin
            if (read && write) flag("bus_rw_both", "read and write high together");
            if (bus_q.size() == 0) begin
                flag("bus_unexpected", "strobe with no transfer expected");
            end else begin
                b = bus_q[0];
                chk("bus_write", {31'b0, write}, {31'b0, b.wr});
                chk("bus_read", {31'b0, read}, {31'b0, ~b.wr});
                chk("bus_be", {28'b0, byteenable}, {28'b0, b.be});
                chk("bus_addr", {8'b0, addr}, {8'b0, b.addr});
                if (b.wr) chk("bus_wdata", writedata, b.wd);
                if (!waitrequest) void'(bus_q.pop_front());
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd, input bit track);
        resp_t r;
        bus_t  b;
        int    k;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            flag("req_ready_timeout", "request never accepted");
        end else begin
            if (track) begin
                r.err = exp_err; r.rdata = exp_rd; r.lat = exp_lat; r.stamp = cyc;
                resp_q.push_back(r);
            end
            if (!exp_err) begin
                b.wr = wr; b.be = exp_be; b.addr = a[23:0]; b.wd = exp_wd;
                bus_q.push_back(b);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (resp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (resp_q.size() != 0) flag("drain_timeout", "outstanding response never arrived");
    endtask

    initial begin
        int k;
        int stamp;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; t_req_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", {31'b0, read}, 32'h0);
        chk("rst_write", {31'b0, write}, 32'h0);
        chk("rst_be", {28'b0, byteenable}, 32'h0);
        chk("rst_addr", {8'b0, addr}, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

        // wr sz sg addr wdata | err rdata lat be wd
        issue(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2, 4'b1111, 32'hDEADBEEF, 1);
        issue(0, 2, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 3, 4'b1111, 32'h0, 1);
        issue(1, 0, 0, 32'h13, 32'h123456A5, 0, 32'h0,        2, 4'b1000, 32'hA5A5A5A5, 1);
        issue(0, 0, 1, 32'h13, 32'h0,        0, 32'hFFFFFFA5, 3, 4'b1000, 32'h0, 1);
        issue(0, 0, 0, 32'h13, 32'h0,        0, 32'h000000A5, 3, 4'b1000, 32'h0, 1);
        issue(1, 1, 0, 32'h12, 32'hFFFF8001, 0, 32'h0,        2, 4'b1100, 32'h80018001, 1);
        issue(0, 1, 1, 32'h12, 32'h0,        0, 32'hFFFF8001, 3, 4'b1100, 32'h0, 1);
        issue(0, 1, 0, 32'h12, 32'h0,        0, 32'h00008001, 3, 4'b1100, 32'h0, 1);
        issue(1, 1, 0, 32'h10, 32'h00001234, 0, 32'h0,        2, 4'b0011, 32'h12341234, 1);
        issue(0, 0, 0, 32'h11, 32'h0,        0, 32'h00000012, 3, 4'b0010, 32'h0, 1);
        issue(0, 1, 1, 32'h10, 32'h0,        0, 32'h00001234, 3, 4'b0011, 32'h0, 1);
        issue(0, 2, 0, 32'h10, 32'h0,        0, 32'h80011234, 3, 4'b1111, 32'h0, 1);
        issue(1, 0, 0, 32'h00, 32'h0000007F, 0, 32'h0,        2, 4'b0001, 32'h7F7F7F7F, 1);
        issue(0, 0, 1, 32'h00, 32'h0,        0, 32'h0000007F, 3, 4'b0001, 32'h0, 1);
        // misaligned: no bus activity, error in cycle 1
        issue(0, 2, 0, 32'h02, 32'h0,        1, 32'h0,        1, 4'b0000, 32'h0, 1);
        issue(0, 1, 1, 32'h13, 32'h0,        1, 32'h0,        1, 4'b0000, 32'h0, 1);
        issue(0, 3, 0, 32'h10, 32'h0,        1, 32'h0,        1, 4'b0000, 32'h0, 1);
        issue(1, 2, 0, 32'h11, 32'h55555555, 1, 32'h0,        1, 4'b0000, 32'h0, 1);
        drain();
        chk("misaligned_store_no_write", {24'b0, mem[32'h11]}, 32'h12);

        // five wait states on a load
        wait_cfg = 5;
        issue(0, 2, 0, 32'h10, 32'h0, 0, 32'h80011234, 8, 4'b1111, 32'h0, 1);
        drain();
        wait_cfg = 0;

        // timeout instance: waitrequest stuck high, TIMEOUT = 4
        @(negedge clk);
        chk("to_req_ready", {31'b0, t_req_ready}, 32'h1);
        t_req_valid = 1'b1;
        stamp = cyc;
        @(negedge clk);
        t_req_valid = 1'b0;
        chk("to_read_cycle1", {31'b0, t_read}, 32'h1);
        k = 0;
        while (!t_resp_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!t_resp_valid) begin
            flag("to_resp_timeout", "no response from timed-out access");
        end else begin
            chk("to_resp_err", {31'b0, t_resp_err}, 32'h1);
            chk("to_resp_rdata", t_resp_rdata, 32'h0);
            chk("to_read_dropped", {31'b0, t_read}, 32'h0);
            chk("to_latency", cyc - stamp, 32'd5);
        end

        // reset during a stalled access abandons it silently
        wait_cfg = 5;
        issue(0, 2, 0, 32'h10, 32'h0, 0, 32'h0, 0, 4'b1111, 32'h0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_read", {31'b0, read}, 32'h0);
        chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_mid_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        reset = 1'b0;
        bus_q.delete();
        wait_cfg = 0;
        repeat (4) @(negedge clk);
        issue(0, 2, 0, 32'h10, 32'h0, 0, 32'h80011234, 3, 4'b1111, 32'h0, 1);
        drain();
        repeat (4) @(negedge clk);
        if (bus_q.size() != 0) flag("bus_leftover", "expected bus transfer never seen");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
